// File: rtl/clk_meas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_meas_pkg
// Description : Shared definitions for the clock period meter: FSM state
//               encodings and the default expected period, which tracks the
//               default divide ratio of the clock divider feeding the meter.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_meas_pkg;

  // Meter FSM state encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MEAS = 1'b1;

  // Divider default ratio; the meter expects exactly this period by default
  localparam int DIV_N_DEFAULT = 24;
  localparam int EXP_N_DEFAULT = DIV_N_DEFAULT;

endpackage : clk_meas_pkg
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : edge_sync
// Description : Two-flop synchronizer plus history flop for a slow
//               asynchronous input, with single-cycle edge detection.
// Revision    : 1.0 - initial release
// Ports       :
//   clk     in   system clock
//   rst_n   in   synchronous reset, active-high
//   i_sig   in   asynchronous input
//   o_s2    out  synchronized level
//   o_rise  out  one-cycle pulse on a synchronized rising edge
//   o_fall  out  one-cycle pulse on a synchronized falling edge
// ============================================================================
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_s2,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_sig;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_s2   = r_s2;
  assign o_rise = r_s2 & ~r_s3;
  assign o_fall = ~r_s2 & r_s3;

endmodule : edge_sync
`default_nettype wire

// File: rtl/clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : clk_period_meter
// Description : Measures period and high time of a slow asynchronous square
//               wave in clk cycles, strobes each completed period, tracks lock
//               against an expected period and flags a stalled input.
// Revision    : 1.0 - initial release
// Ports       :
//   clk         in   system clock
//   rst_n       in   synchronous reset, active-high despite the name
//   sig_in      in   asynchronous slow square wave
//   period      out  last rising-to-rising period, in cycles
//   high_cnt    out  high time of the last completed period, in cycles
//   meas_valid  out  one-cycle strobe, period/high_cnt updated this cycle
//   locked      out  period in EXP_N+/-TOL for LOCK_CNT consecutive periods
//   timeout     out  sticky stall flag, cleared by the next measurement
// ============================================================================
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int EXP_N       = EXP_N_DEFAULT,
  parameter int TOL         = 1,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int               LK_W      = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] C_TOL_LO  = CNT_W'(EXP_N - TOL);
  localparam logic [CNT_W-1:0] C_TOL_HI  = CNT_W'(EXP_N + TOL);
  localparam logic [LK_W-1:0]  C_LK_MAX  = LK_W'(LOCK_CNT);

  logic w_s2;
  logic w_rise;
  logic w_fall;

  edge_sync u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sig  (sig_in),
    .o_s2   (w_s2),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // --------------------------------------------------------------------------
  // Free-running counters
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hcnt;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= '0;
    end else if (r_cnt != C_CNT_MAX) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // The rise cycle is high but is spent clearing the counter; counting the
  // fall cycle instead keeps hcnt equal to the full high time, and it then
  // stays frozen until the next rise.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_hcnt <= '0;
    end else if (w_rise) begin
      r_hcnt <= '0;
    end else if ((w_s2 || w_fall) && (r_hcnt != C_CNT_MAX)) begin
      r_hcnt <= r_hcnt + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic       w_capture;
  logic       w_stall;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_rise) w_state_nxt = ST_MEAS;
      ST_MEAS: if (!w_rise && (r_cnt == C_TO_LAST)) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A rise on the timeout cycle wins: it is a capture, not a stall.
  always_comb begin
    w_capture = 1'b0;
    w_stall   = 1'b0;
    if (r_state == ST_MEAS) begin
      w_capture = w_rise;
      w_stall   = !w_rise && (r_cnt == C_TO_LAST);
    end
  end

  // --------------------------------------------------------------------------
  // Measurement, lock and timeout registers
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] w_period_new;
  logic             w_in_tol;
  logic [LK_W-1:0]  w_lock_inc;

  // cnt was cleared on the previous rise, so it reads period-1 here
  assign w_period_new = r_cnt + CNT_W'(1);
  assign w_in_tol     = (w_period_new >= C_TOL_LO) && (w_period_new <= C_TOL_HI);

  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_valid;
  logic             r_locked;
  logic             r_timeout;
  logic [LK_W-1:0]  r_lock_cnt;

  assign w_lock_inc = (r_lock_cnt == C_LK_MAX) ? r_lock_cnt : r_lock_cnt + LK_W'(1);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_period   <= '0;
      r_high     <= '0;
      r_valid    <= 1'b0;
      r_locked   <= 1'b0;
      r_timeout  <= 1'b0;
      r_lock_cnt <= '0;
    end else begin
      r_valid <= w_capture;
      if (w_capture) begin
        r_period  <= w_period_new;
        r_high    <= r_hcnt;
        r_timeout <= 1'b0;
        if (w_in_tol) begin
          r_lock_cnt <= w_lock_inc;
          r_locked   <= (w_lock_inc == C_LK_MAX);
        end else begin
          r_lock_cnt <= '0;
          r_locked   <= 1'b0;
        end
      end else if (w_stall) begin
        r_timeout  <= 1'b1;
        r_locked   <= 1'b0;
        r_lock_cnt <= '0;
      end
    end
  end

  assign period     = r_period;
  assign high_cnt   = r_high;
  assign meas_valid = r_valid;
  assign locked     = r_locked;
  assign timeout    = r_timeout;

endmodule : clk_period_meter
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_period_meter
// Description : Self-checking bench for clk_period_meter. Drives directed
//               high/low sequences on sig_in and compares every strobe and
//               the stall/reset corner cases against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_period_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sig_in;
  logic [31:0] period;
  logic [31:0] high_cnt;
  logic        meas_valid;
  logic        locked;
  logic        timeout;

  always #5 clk = ~clk;

  clk_period_meter #(
    .CNT_W       (32),
    .EXP_N       (24),
    .TOL         (1),
    .LOCK_CNT    (4),
    .TIMEOUT_CYC (1024)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .period     (period),
    .high_cnt   (high_cnt),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  typedef struct {
    int          hi;
    int          lo;
    logic [31:0] exp_p;
    logic [31:0] exp_h;
    logic        exp_lk;
  } vec_t;

  typedef struct {
    logic [31:0] p;
    logic [31:0] h;
    logic        lk;
    logic        to;
    int          cyc;
  } stb_t;

  vec_t vt[12];
  stb_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic prev_mv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_next(input string nm, input logic [31:0] ep, input logic [31:0] eh,
                            input logic elk, input logic eto);
    stb_t s;
    if (q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: no strobe seen, expected period %0d", nm, ep);
    end else begin
      s = q.pop_front();
      chk({nm, "_period"}, s.p, ep);
      chk({nm, "_high"}, s.h, eh);
      chk({nm, "_locked"}, 32'(s.lk), 32'(elk));
      chk({nm, "_timeout"}, 32'(s.to), 32'(eto));
    end
  endtask

  // Called at posedge+1; sig_in sampled high for hi edges then low for lo edges
  task automatic drive(input int hi, input int lo);
    sig_in = 1'b1;
    repeat (hi) @(posedge clk);
    #1;
    sig_in = 1'b0;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  // Strobe monitor: records every strobe and checks the per-strobe invariants
  always @(negedge clk) begin
    stb_t s;
    if (rst_n == 1'b0 && meas_valid) begin
      chk("strobe_back_to_back", 32'(prev_mv), 32'd0);
      chk("high_lt_period", 32'(high_cnt < period), 32'd1);
      s.p   = period;
      s.h   = high_cnt;
      s.lk  = locked;
      s.to  = timeout;
      s.cyc = cyc;
      q.push_back(s);
    end
    prev_mv <= meas_valid;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    int last_cyc;

    vt[0]  = '{12, 12, 32'd24, 32'd12, 1'b0};
    vt[1]  = '{12, 12, 32'd24, 32'd12, 1'b0};
    vt[2]  = '{12, 12, 32'd24, 32'd12, 1'b0};
    vt[3]  = '{12, 12, 32'd24, 32'd12, 1'b1};
    vt[4]  = '{12, 11, 32'd23, 32'd12, 1'b1};
    vt[5]  = '{12, 13, 32'd25, 32'd12, 1'b1};
    vt[6]  = '{11, 11, 32'd22, 32'd11, 1'b0};
    vt[7]  = '{12, 12, 32'd24, 32'd12, 1'b0};
    vt[8]  = '{12, 12, 32'd24, 32'd12, 1'b0};
    vt[9]  = '{12, 12, 32'd24, 32'd12, 1'b0};
    vt[10] = '{12, 12, 32'd24, 32'd12, 1'b1};
    vt[11] = '{ 5, 19, 32'd24, 32'd5,  1'b1};

    // Reset values
    rst_n  = 1'b1;
    sig_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_period", period, 32'd0);
    chk("rst_high", high_cnt, 32'd0);
    chk("rst_valid", 32'(meas_valid), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Table-driven periods: each record is measured at the next record's rise
    foreach (vt[i]) drive(vt[i].hi, vt[i].lo);
    drive(12, 12);  // closing rise, then the input stalls low
    chk("vec_strobe_count", 32'(q.size()), 32'd12);
    last_cyc = (q.size() > 0) ? q[q.size()-1].cyc : cyc;
    for (int i = 0; i < 12; i++)
      check_next($sformatf("vec%0d", i), vt[i].exp_p, vt[i].exp_h, vt[i].exp_lk, 1'b0);

    // Stall: timeout exactly 1024 cycles after the last strobe/rise
    while (cyc < last_cyc + 1023) @(negedge clk);
    chk("stall_timeout_early", 32'(timeout), 32'd0);
    @(negedge clk);
    chk("stall_timeout", 32'(timeout), 32'd1);
    chk("stall_locked", 32'(locked), 32'd0);
    chk("stall_period_hold", period, 32'd24);
    chk("stall_high_hold", high_cnt, 32'd5);
    @(posedge clk);
    #1;

    // Re-arm: first rise only arms, second measures and clears timeout
    drive(12, 12);
    chk("rearm_no_strobe", 32'(q.size()), 32'd0);
    chk("rearm_timeout_held", 32'(timeout), 32'd1);
    drive(12, 1012);
    check_next("rearm", 32'd24, 32'd12, 1'b0, 1'b0);
    chk("rearm_timeout_cleared", 32'(timeout), 32'd0);

    // Rise lands exactly on the timeout cycle: measurement wins
    drive(12, 12);
    check_next("to_edge", 32'd1024, 32'd12, 1'b0, 1'b0);
    chk("to_edge_timeout", 32'(timeout), 32'd0);

    // One-cycle reset mid-measurement with the input high at release
    q.delete();
    rst_n  = 1'b1;
    sig_in = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    chk("midrst_period", period, 32'd0);
    chk("midrst_high", high_cnt, 32'd0);
    chk("midrst_valid", 32'(meas_valid), 32'd0);
    chk("midrst_locked", 32'(locked), 32'd0);
    chk("midrst_timeout", 32'(timeout), 32'd0);
    drive(12, 12);
    chk("midrst_arm_only", 32'(q.size()), 32'd0);

    // Asymmetric duty after re-arming
    drive(5, 19);
    chk("duty_arm_strobe", 32'(q.size()), 32'd1);
    q.delete();
    drive(12, 12);
    check_next("duty", 32'd24, 32'd5, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_clk_period_meter
`default_nettype wire

// File: doc/clk_period_meter.md
# clk_period_meter

Measuring end for divided clocks and slow strobes. Takes a slow square wave (a divider output, or a pulse train from the 52 MCU), brings it into the `clk` domain and measures its period and high time in `clk` cycles. It reports each completed period with a one-cycle valid strobe, raises `locked` once the period matches the expected divide ratio, and flags a stalled input.

## Interface
Parameters:
- `CNT_W`, 32: width of all cycle counters and measurement outputs.
- `EXP_N`, 24: expected period in `clk` cycles, matching the default divider ratio.
- `TOL`, 1: allowed ± deviation from `EXP_N` for a period to count as in tolerance.
- `LOCK_CNT`, 4: consecutive in-tolerance periods required to assert `locked`.
- `TIMEOUT_CYC`, 1024: cycles without a rising edge before a timeout is declared; must exceed `EXP_N+TOL`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, synchronous, active-high (asserted = 1, despite the name).
- `sig_in`  in  1  asynchronous slow square wave.
- `period`  out  CNT_W  last measured rising-to-rising period, in cycles.
- `high_cnt`  out  CNT_W  high time of the last completed period, in cycles.
- `meas_valid`  out  1  one-cycle strobe; `period` and `high_cnt` were updated this cycle.
- `locked`  out  1  period has been within `EXP_N±TOL` for `LOCK_CNT` consecutive periods.
- `timeout`  out  1  sticky stall flag.

## Operation
Input conditioning:
- 2-FF synchronizer `s1`, `s2`, followed by history flop `s3`.
- `rise = s2 & ~s3`; `fall = ~s2 & s3`.
- All three flops reset to 0. An input already high at reset release therefore produces a rise 3 cycles later; that rise only arms the meter.

Counters:
- `cnt` increments every cycle, saturates at all-ones, and clears to 0 on `rise`.
- `hcnt` clears on `rise`, increments while `s2 = 1`, and freezes on `fall`.

FSM:
- **IDLE**
  - On `rise`: go to MEAS, clear `cnt` and `hcnt`, no strobe.
- **MEAS**
  - On `rise`: `period <= cnt+1`, `high_cnt <= hcnt`, pulse `meas_valid`, clear `timeout`, update lock logic. Stay in MEAS.
  - If `cnt == TIMEOUT_CYC-1` with no `rise` that cycle: go to IDLE, set `timeout`, clear `locked` and the lock counter. `period` and `high_cnt` hold their values.

Lock logic:
- A period is in tolerance when `EXP_N-TOL <= period_new <= EXP_N+TOL`; the comparison is unsigned on `CNT_W` bits.
- In tolerance: the lock counter increments and saturates at `LOCK_CNT`. `locked` asserts the same cycle the counter reaches `LOCK_CNT`.
- Out of tolerance: the counter clears and `locked` deasserts the same cycle.

Boundary rules:
- Rise on the timeout cycle: the rise wins. The period is measured and no timeout occurs.
- A pulse shorter than 2 cycles may be missed; no requirement applies.
- If `high_cnt` would exceed `period`, that is impossible by construction; the bench asserts `high_cnt < period`.
- Reset mid-measurement: next cycle all outputs are 0 and the FSM is in IDLE.

## Timing
- Reset values: `period = 0`, `high_cnt = 0`, `meas_valid = 0`, `locked = 0`, `timeout = 0`; FSM in IDLE.
- Latency: `sig_in` edge to `rise` is 2–3 cycles. `meas_valid` asserts the cycle after `rise` is seen, when the registered outputs update.
- Constant latency means the measured period equals the true period in `clk` cycles.
- `meas_valid` is never high on two consecutive cycles.
- There is no backpressure; consumers sample on the strobe.

## Structure
- Shared package `clk_meas_pkg` holds:
  - FSM state encodings `ST_IDLE = 1'b0`, `ST_MEAS = 1'b1`.
  - The default `EXP_N`, which must agree with the divider default of 24.
- Sub-module `edge_sync`: synchronizer plus history flop, outputs `s2`, `rise`, `fall`. The debounce/edge logic for MCU inputs reuses it.

## Test plan
- **Divider input.** Drive `sig_in` from the 24× divider, 12 cycles high / 12 low. Required response:
  - First strobe ≈ 24 cycles after arming, with `period = 24`, `high_cnt = 12`.
  - `locked = 1` on the 4th strobe.
- **Tolerance edges.** Periods 23, 25, 22. Required response: 23 and 25 keep the lock count, 22 drops `locked` that cycle, and four more 24s relock.
- **Stall.** Stop toggling after lock. Required response:
  - `timeout = 1` and `locked = 0` exactly 1024 cycles after the last `rise`.
  - `period` holds 24.
  - The next two rises re-arm and then give one strobe that clears `timeout`.
- **Rise on the timeout cycle.** Use a period of exactly 1024. Required response: `period = 1024`, `timeout = 0`.
- **Reset mid-measurement.** Assert `rst_n = 1` for one cycle during MEAS. Required response: all outputs 0 next cycle; an input high at release arms only, with no strobe.
- **Asymmetric duty.** 5 cycles high / 19 low. Required response: `period = 24`, `high_cnt = 5`.
